// File: rtl/fifo_uart_tx_if.sv
// Signal bundle between the show-ahead FIFO read port, the UART transmitter and the TX pin.
// The master side is the FIFO/board; the slave side is the transmitter.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  serial_out;
  logic                  busy;

  modport master (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en,
    input  serial_out,
    input  busy
  );

  modport slave (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en,
    output serial_out,
    output busy
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter: pops a byte whenever the FIFO is non-empty and
// serialises it start bit first, data LSB-first, then stop, with no gap between frames.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLOCK_FREQ = 125000000,
  parameter int BAUD_RATE  = 115200
) (
  input logic           clk,
  input logic           rst_n,
  fifo_uart_tx_if.slave bus
);

  localparam int CPB   = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bitCnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_serialOut;
  logic                  r_busy;

  logic w_lastTick;
  logic w_pop;

  assign w_lastTick = (r_cnt == CNT_W'(CPB - 1));

  // The next byte is popped either from idle or on the final cycle of a stop bit,
  // which is what makes back-to-back frames seamless.
  assign w_pop = rst_n && !bus.fifo_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_lastTick));

  assign bus.fifo_rd_en = w_pop;
  assign bus.serial_out = r_serialOut;
  assign bus.busy       = r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_serialOut <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_state     <= START;
            r_shift     <= bus.fifo_dout;
            r_serialOut <= 1'b0;
            r_busy      <= 1'b1;
          end
        end

        START: begin
          if (w_lastTick) begin
            r_state     <= DATA;
            r_cnt       <= '0;
            r_bitCnt    <= '0;
            r_serialOut <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // serial_out is registered, so it is loaded with the bit that becomes shift[0] next.
        DATA: begin
          if (w_lastTick) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bitCnt == BIT_W'(DATA_WIDTH - 1)) begin
              r_state     <= STOP;
              r_serialOut <= 1'b1;
            end else begin
              r_bitCnt    <= r_bitCnt + BIT_W'(1);
              r_serialOut <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (w_lastTick) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_state     <= START;
              r_shift     <= bus.fifo_dout;
              r_serialOut <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_serialOut <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue-backed FIFO model feeds the DUT and a
// line decoder turns serial_out back into bytes for comparison.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CF  = 1000;
  localparam int BR  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  fifo_uart_tx #(
    .DATA_WIDTH(DW),
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic [7:0] decoded[$];
  logic [7:0] expStream[$];
  int         popTimes[$];
  int         cycle = 0;

  logic       ovr = 1'b1;
  logic [7:0] ovrDout = 8'hEE;
  logic       ovrEmpty = 1'b0;

  logic       decoding = 1'b0;
  int         dcnt = 0;
  logic [7:0] dbyte = 8'h00;

  // Pops happen on the DUT's own clock edge; the FIFO outputs are refreshed on the
  // falling edge so they never change at the edge the DUT samples them.
  always @(posedge clk) begin
    cycle++;
    if (bus.fifo_rd_en) begin
      checks++;
      assert (bus.fifo_empty === 1'b0)
      else begin
        errors++;
        $error("[TB] FAIL underflow: observed fifo_empty=%b with rd_en=1, expected 0", bus.fifo_empty);
      end
      popTimes.push_back(cycle);
      if (!ovr && q.size() > 0) q.delete(0);
    end
  end

  // UART line decoder samples each bit at its midpoint.
  always @(negedge clk) begin
    if (ovr) begin
      bus.fifo_dout  = ovrDout;
      bus.fifo_empty = ovrEmpty;
    end else begin
      bus.fifo_empty = (q.size() == 0);
      bus.fifo_dout  = (q.size() > 0) ? q[0] : 8'h00;
    end

    if (!rst_n) begin
      decoding = 1'b0;
    end else if (!decoding) begin
      if (bus.serial_out == 1'b0) begin
        decoding = 1'b1;
        dcnt     = 0;
      end
    end else begin
      dcnt++;
      if (dcnt >= 15 && dcnt <= 85 && ((dcnt - 15) % 10) == 0)
        dbyte = {bus.serial_out, dbyte[7:1]};
      if (dcnt == 95) begin
        checks++;
        assert (bus.serial_out === 1'b1)
        else begin
          errors++;
          $error("[TB] FAIL stop_bit: observed=%b expected=1", bus.serial_out);
        end
        decoded.push_back(dbyte);
        decoding = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    q.push_back(b);
    expStream.push_back(b);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] decAt(input int k);
    return (decoded.size() > k) ? 32'(decoded[k]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] popGap(input int k);
    return (popTimes.size() > k + 1) ? 32'(popTimes[k+1] - popTimes[k]) : 32'hDEAD_BEEF;
  endfunction

  logic [9:0] frameA5;
  logic [7:0] gotBit;

  initial begin
    // Reset held with a non-empty FIFO must not pop.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("rst_rd_en", 32'(bus.fifo_rd_en), 32'h0);
    end
    ovrEmpty = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checkOutput("rst_serial", 32'(bus.serial_out), 32'h1);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_idle_rd_en", 32'(bus.fifo_rd_en), 32'h0);
    ovr = 1'b0;
    tick(2);

    // Single byte 0xA5: frame bits 0,1,0,1,0,0,1,0,1,1.
    frameA5 = 10'b1101001010;
    decoded.delete();
    popTimes.delete();
    applyStimulus(8'hA5);
    tick(1);
    checkOutput("a5_pop", 32'(bus.fifo_rd_en), 32'h1);
    tick(1);
    checkOutput("a5_no_second_pop", 32'(bus.fifo_rd_en), 32'h0);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 10; c++) begin
        gotBit = {7'd0, bus.serial_out};
        checkOutput($sformatf("a5_bit%0d_c%0d", b, c), 32'(gotBit), 32'(frameA5[b]));
        checkOutput("a5_busy", 32'(bus.busy), 32'h1);
        tick(1);
      end
    end
    checkOutput("a5_end_busy", 32'(bus.busy), 32'h0);
    checkOutput("a5_end_serial", 32'(bus.serial_out), 32'h1);
    checkOutput("a5_pop_count", 32'(popTimes.size()), 32'd1);
    checkOutput("a5_decoded", decAt(0), 32'hA5);
    tick(2);

    // Three queued bytes go out back-to-back.
    decoded.delete();
    popTimes.delete();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    tick(320);
    checkOutput("b2b_pops", 32'(popTimes.size()), 32'd3);
    checkOutput("b2b_gap0", popGap(0), 32'd100);
    checkOutput("b2b_gap1", popGap(1), 32'd100);
    checkOutput("b2b_byte0", decAt(0), 32'h00);
    checkOutput("b2b_byte1", decAt(1), 32'hFF);
    checkOutput("b2b_byte2", decAt(2), 32'h3C);
    checkOutput("b2b_rd_en_empty", 32'(bus.fifo_rd_en), 32'h0);
    checkOutput("b2b_busy_end", 32'(bus.busy), 32'h0);

    // FIFO outputs wiggle mid-frame; only the popped 0x5A may be sent.
    decoded.delete();
    popTimes.delete();
    ovrDout  = 8'h5A;
    ovrEmpty = 1'b0;
    ovr      = 1'b1;
    tick(1);
    checkOutput("mid_pop", 32'(bus.fifo_rd_en), 32'h1);
    tick(1);
    ovrDout  = 8'h11;
    ovrEmpty = 1'b1;
    tick(20);
    ovrDout  = 8'h99;
    ovrEmpty = 1'b0;
    tick(30);
    checkOutput("mid_rd_en_busy", 32'(bus.fifo_rd_en), 32'h0);
    ovrEmpty = 1'b1;
    tick(30);
    ovrDout = 8'hFF;
    tick(30);
    checkOutput("mid_pop_count", 32'(popTimes.size()), 32'd1);
    checkOutput("mid_decoded_n", 32'(decoded.size()), 32'd1);
    checkOutput("mid_decoded", decAt(0), 32'h5A);
    ovr = 1'b0;
    tick(2);

    // Reset during data bit 3 of 0xC3 drops the frame; 0x81 follows cleanly.
    decoded.delete();
    popTimes.delete();
    applyStimulus(8'hC3);
    applyStimulus(8'h81);
    tick(1);
    checkOutput("abort_pop", 32'(bus.fifo_rd_en), 32'h1);
    tick(1);
    tick(44);
    checkOutput("abort_bit3", 32'(bus.serial_out), 32'h0);
    checkOutput("abort_busy_pre", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_rd_en_in_reset", 32'(bus.fifo_rd_en), 32'h0);
    tick(1);
    checkOutput("abort_serial", 32'(bus.serial_out), 32'h1);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_idle_pop", 32'(bus.fifo_rd_en), 32'h1);
    tick(1);
    checkOutput("abort_next_start", 32'(bus.serial_out), 32'h0);
    tick(110);
    checkOutput("abort_decoded_n", 32'(decoded.size()), 32'd1);
    checkOutput("abort_decoded", decAt(0), 32'h81);
    tick(2);

    // Random stream through the FIFO model and line decoder.
    decoded.delete();
    expStream.delete();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom_range(255, 0)));
      if ($urandom_range(3, 0) == 0) tick(int'($urandom_range(150, 0)));
    end
    for (int w = 0; w < 4000 && decoded.size() < 20; w++) tick(1);
    checkOutput("rand_count", 32'(decoded.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      checkOutput($sformatf("rand_byte%0d", i), decAt(i), 32'(expStream[i]));
    tick(5);
    checkOutput("rand_idle_busy", 32'(bus.busy), 32'h0);
    checkOutput("rand_idle_rd_en", 32'(bus.fifo_rd_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
